// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-lite delay slave.
// Holds the response codes, delay-mode selectors, FSM state types, the
// LFSR tap mask and the helper that picks a transaction's response latency.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned DELAY_NONE = 0;
    localparam int unsigned DELAY_FIX  = 1;
    localparam int unsigned DELAY_RAND = 2;

    // Latency counter width; random delays are 8-bit LFSR values
    localparam int unsigned CNT_W = 8;

    // Galois toggle mask for x^8+x^6+x^5+x^4+1 in right-shift form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

    // Latency for one transaction, taken from the LFSR value at acceptance
    function automatic logic [CNT_W-1:0] pick_delay(
        input int unsigned mode,
        input int unsigned fix,
        input logic [7:0]  mask,
        input logic [7:0]  lfsr
    );
        logic [CNT_W-1:0] d;
        case (mode)
            DELAY_NONE: d = '0;
            DELAY_FIX:  d = CNT_W'(fix);
            default:    d = lfsr & mask;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/axi_lite_delay_slave_lfsr8.sv
// 8-bit Galois LFSR used to draw random response latencies.
// Ports: clk, rst (sync, active-high, loads seed), seed[7:0],
//        en (advance one step), out[7:0] (current state, registered).
module lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] out
);
    import axi_lite_pkg::*;

    logic [7:0] state_q;
    logic [7:0] state_d;

    // Next state: shift right, fold the tap mask in when a one falls out
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {1'b0, state_q[7:1]} ^ (state_q[0] ? LFSR_TAPS : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;

endmodule

// File: rtl/axi_lite_delay_slave.sv
// AXI4-lite memory slave with per-transaction injected response latency.
// Read and write channels are independent, each with one outstanding
// transaction and its own latency counter and LFSR.
// Ports: clk, rst (sync, active-high);
//        AR: araddr, arvalid, arready   R: rdata, rresp, rvalid, rready
//        AW: awaddr, awvalid, awready   W: wdata, wstrb, wvalid, wready
//        B:  bresp, bvalid, bready
module axi_lite_delay_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        DEPTH      = 1024,
    parameter logic [ADDR_W-1:0]  BASE       = ADDR_W'(32'h8000_0000),
    parameter int unsigned        DELAY_MODE = 2,
    parameter int unsigned        FIX_DELAY  = 3,
    parameter logic [7:0]         DELAY_MASK = 8'h0F,
    parameter logic [7:0]         RD_SEED    = 8'hA5,
    parameter logic [7:0]         WR_SEED    = 8'h3C
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int unsigned BYTES   = DATA_W / 8;
    localparam int unsigned IDX_LSB = $clog2(BYTES);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

    // Address lies inside the backing store window
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    // Word index; byte-offset bits are dropped
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return IDX_W'(off >> IDX_LSB);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // Read channel state
    rd_state_e         rd_state_q, rd_state_d;
    logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
    logic [ADDR_W-1:0] araddr_q,   araddr_d;
    logic              arready_q,  arready_d;
    logic              rvalid_q,   rvalid_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic [1:0]        rresp_q,    rresp_d;

    // Write channel state
    wr_state_e         wr_state_q, wr_state_d;
    logic [CNT_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic [ADDR_W-1:0] awaddr_q,   awaddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic [BYTES-1:0]  wstrb_q,    wstrb_d;
    logic              aw_done_q,  aw_done_d;
    logic              w_done_q,   w_done_d;
    logic              awready_q,  awready_d;
    logic              wready_q,   wready_d;
    logic              bvalid_q,   bvalid_d;
    logic [1:0]        bresp_q,    bresp_d;

    logic              ar_hs_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [CNT_W-1:0]  rd_delay_c;
    logic              aw_hs_c;
    logic              w_hs_c;
    logic              aw_have_c;
    logic              w_have_c;
    logic              wr_accept_c;
    logic              wr_commit_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic [BYTES-1:0]  wr_strb_c;
    logic [CNT_W-1:0]  wr_delay_c;
    logic [7:0]        rd_lfsr;
    logic [7:0]        wr_lfsr;

    lfsr8 u_rd_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (RD_SEED),
        .en   (ar_hs_c),
        .out  (rd_lfsr)
    );

    lfsr8 u_wr_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (WR_SEED),
        .en   (wr_accept_c),
        .out  (wr_lfsr)
    );

    // Read FSM next state; the address mux lets a zero-delay read sample
    // memory on its own acceptance edge
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        araddr_d   = araddr_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ar_hs_c    = arvalid & arready_q;
        rd_addr_c  = ar_hs_c ? araddr : araddr_q;
        rd_delay_c = pick_delay(DELAY_MODE, FIX_DELAY, DELAY_MASK, rd_lfsr);

        case (rd_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_c) begin
                    araddr_d  = araddr;
                    arready_d = 1'b0;
                    rd_cnt_d  = rd_delay_c;
                    if (rd_delay_c == '0) begin
                        rvalid_d   = 1'b1;
                        rdata_d    = addr_ok(rd_addr_c) ? mem[addr_idx(rd_addr_c)] : '0;
                        rresp_d    = addr_ok(rd_addr_c) ? RESP_OKAY : RESP_SLVERR;
                        rd_state_d = R_RESP;
                    end else begin
                        rd_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == CNT_W'(1)) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = addr_ok(rd_addr_c) ? mem[addr_idx(rd_addr_c)] : '0;
                    rresp_d    = addr_ok(rd_addr_c) ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = R_RESP;
                end else begin
                    rd_cnt_d = rd_cnt_q - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d   = 1'b0;
                    arready_d  = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state; AW and W are collected independently and the
    // transaction starts once both are held (including same-edge arrival)
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        aw_hs_c     = awvalid & awready_q;
        w_hs_c      = wvalid & wready_q;
        aw_have_c   = aw_done_q | aw_hs_c;
        w_have_c    = w_done_q | w_hs_c;
        wr_accept_c = 1'b0;
        wr_commit_c = 1'b0;
        wr_addr_c   = aw_hs_c ? awaddr : awaddr_q;
        wr_data_c   = w_hs_c ? wdata : wdata_q;
        wr_strb_c   = w_hs_c ? wstrb : wstrb_q;
        wr_delay_c  = pick_delay(DELAY_MODE, FIX_DELAY, DELAY_MASK, wr_lfsr);

        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    awaddr_d = awaddr;
                end
                if (w_hs_c) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                awready_d = ~aw_have_c;
                wready_d  = ~w_have_c;
                aw_done_d = aw_have_c;
                w_done_d  = w_have_c;
                if (aw_have_c && w_have_c) begin
                    wr_accept_c = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    wr_cnt_d    = wr_delay_c;
                    if (wr_delay_c == '0) begin
                        wr_commit_c = 1'b1;
                        bvalid_d    = 1'b1;
                        bresp_d     = addr_ok(wr_addr_c) ? RESP_OKAY : RESP_SLVERR;
                        wr_state_d  = W_RESP;
                    end else begin
                        wr_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == CNT_W'(1)) begin
                    wr_commit_c = 1'b1;
                    bvalid_d    = 1'b1;
                    bresp_d     = addr_ok(wr_addr_c) ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d  = W_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q - CNT_W'(1);
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d   = 1'b0;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Channel registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            araddr_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            araddr_q   <= araddr_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Backing store is never cleared; a commit is suppressed under reset
    always_ff @(posedge clk) begin
        if (!rst && wr_commit_c && addr_ok(wr_addr_c)) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (wr_strb_c[b]) begin
                    mem[addr_idx(wr_addr_c)][8*b +: 8] <= wr_data_c[8*b +: 8];
                end
            end
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_delay_slave.sv
// Bench for axi_lite_delay_slave: three instances (no delay, fixed delay,
// random delay) driven by directed and randomized transactions and checked
// against a word-array memory model plus a reference latency generator.
module tb_axi_lite_delay_slave;

    localparam logic [31:0] BASE_A = 32'h8000_0000;
    localparam logic [31:0] END_A  = 32'h8000_1000;

    logic        clk;
    logic        rst;
    logic [31:0] araddr_i [3];
    logic        arvalid_i [3];
    logic        arready_o [3];
    logic [31:0] rdata_o [3];
    logic [1:0]  rresp_o [3];
    logic        rvalid_o [3];
    logic        rready_i [3];
    logic [31:0] awaddr_i [3];
    logic        awvalid_i [3];
    logic        awready_o [3];
    logic [31:0] wdata_i [3];
    logic [3:0]  wstrb_i [3];
    logic        wvalid_i [3];
    logic        wready_o [3];
    logic [1:0]  bresp_o [3];
    logic        bvalid_o [3];
    logic        bready_i [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_lite_delay_slave #(.DELAY_MODE(g)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .araddr  (araddr_i[g]),
            .arvalid (arvalid_i[g]),
            .arready (arready_o[g]),
            .rdata   (rdata_o[g]),
            .rresp   (rresp_o[g]),
            .rvalid  (rvalid_o[g]),
            .rready  (rready_i[g]),
            .awaddr  (awaddr_i[g]),
            .awvalid (awvalid_i[g]),
            .awready (awready_o[g]),
            .wdata   (wdata_i[g]),
            .wstrb   (wstrb_i[g]),
            .wvalid  (wvalid_i[g]),
            .wready  (wready_o[g]),
            .bresp   (bresp_o[g]),
            .bvalid  (bvalid_o[g]),
            .bready  (bready_i[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks;
    int         failures;
    logic [31:0] mem_m [3][1024];
    logic [7:0]  rd_lfsr_m [3];
    logic [7:0]  wr_lfsr_m [3];
    int          pool [16];
    bit          seen [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Polynomial x^8+x^6+x^5+x^4+1, one Galois step
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        logic [7:0] n;
        n = x >> 1;
        if (x[0]) n = n ^ 8'b1011_1000;
        return n;
    endfunction

    function automatic int exp_delay(input int k, input logic [7:0] l);
        if (k == 0) return 0;
        if (k == 1) return 3;
        return int'(l & 8'h0F);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE_A) && (a < END_A);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE_A) / 32'd4);
    endfunction

    task automatic reseed_models();
        for (int k = 0; k < 3; k++) begin
            rd_lfsr_m[k] = 8'hA5;
            wr_lfsr_m[k] = 8'h3C;
        end
    endtask

    task automatic do_read(input int k, input logic [31:0] addr, input int hold, output int lat);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        int          exp_lat;
        exp_d   = in_rng(addr) ? mem_m[k][widx(addr)] : 32'h0;
        exp_r   = in_rng(addr) ? 2'b00 : 2'b10;
        exp_lat = exp_delay(k, rd_lfsr_m[k]);
        rd_lfsr_m[k] = lfsr_step(rd_lfsr_m[k]);
        check("arready_idle", 64'(arready_o[k]), 64'(1));
        araddr_i[k]  = addr;
        arvalid_i[k] = 1'b1;
        @(posedge clk); #1;
        arvalid_i[k] = 1'b0;
        check("arready_drop", 64'(arready_o[k]), 64'(0));
        lat = 0;
        while (rvalid_o[k] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            check("rd_hold_valid", 64'(rvalid_o[k]), 64'(1));
            check("rd_hold_data", 64'(rdata_o[k]), 64'(exp_d));
            @(posedge clk); #1;
        end
        check("rdata", 64'(rdata_o[k]), 64'(exp_d));
        check("rresp", 64'(rresp_o[k]), 64'(exp_r));
        rready_i[k] = 1'b1;
        @(posedge clk); #1;
        rready_i[k] = 1'b0;
        check("rvalid_clear", 64'(rvalid_o[k]), 64'(0));
        check("arready_back", 64'(arready_o[k]), 64'(1));
    endtask

    // order: 0 = AW and W together, 1 = W first, 2 = AW first (by gap cycles)
    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int order, input int gap);
        int lat;
        int exp_lat;
        exp_lat = exp_delay(k, wr_lfsr_m[k]);
        wr_lfsr_m[k] = lfsr_step(wr_lfsr_m[k]);
        check("awready_idle", 64'(awready_o[k]), 64'(1));
        check("wready_idle", 64'(wready_o[k]), 64'(1));
        awaddr_i[k] = addr;
        wdata_i[k]  = data;
        wstrb_i[k]  = strb;
        if (order == 0) begin
            awvalid_i[k] = 1'b1;
            wvalid_i[k]  = 1'b1;
            @(posedge clk); #1;
            awvalid_i[k] = 1'b0;
            wvalid_i[k]  = 1'b0;
        end else begin
            if (order == 1) wvalid_i[k] = 1'b1; else awvalid_i[k] = 1'b1;
            @(posedge clk); #1;
            wvalid_i[k]  = 1'b0;
            awvalid_i[k] = 1'b0;
            check("first_ready_drop", 64'(order == 1 ? wready_o[k] : awready_o[k]), 64'(0));
            check("other_ready_high", 64'(order == 1 ? awready_o[k] : wready_o[k]), 64'(1));
            for (int i = 1; i < gap; i++) begin
                @(posedge clk); #1;
                check("no_early_bvalid", 64'(bvalid_o[k]), 64'(0));
            end
            if (order == 1) awvalid_i[k] = 1'b1; else wvalid_i[k] = 1'b1;
            @(posedge clk); #1;
            wvalid_i[k]  = 1'b0;
            awvalid_i[k] = 1'b0;
        end
        lat = 0;
        while (bvalid_o[k] !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("wr_latency", 64'(lat), 64'(exp_lat));
        check("bresp", 64'(bresp_o[k]), 64'(in_rng(addr) ? 2'b00 : 2'b10));
        bready_i[k] = 1'b1;
        @(posedge clk); #1;
        bready_i[k] = 1'b0;
        check("bvalid_clear", 64'(bvalid_o[k]), 64'(0));
        check("awready_back", 64'(awready_o[k]), 64'(1));
        check("wready_back", 64'(wready_o[k]), 64'(1));
        if (in_rng(addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_m[k][widx(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    initial begin
        int lat;
        int distinct;
        int guard;
        logic [31:0] a;
        checks   = 0;
        failures = 0;
        reseed_models();
        for (int k = 0; k < 3; k++) begin
            araddr_i[k] = '0; arvalid_i[k] = 1'b0; rready_i[k] = 1'b0;
            awaddr_i[k] = '0; awvalid_i[k] = 1'b0; wdata_i[k] = '0;
            wstrb_i[k]  = '0; wvalid_i[k]  = 1'b0; bready_i[k] = 1'b0;
        end
        for (int i = 0; i < 16; i++) pool[i] = i * 61;

        // Reset values, then readies one cycle after release
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_arready", 64'(arready_o[k]), 64'(0));
            check("rst_awready", 64'(awready_o[k]), 64'(0));
            check("rst_wready", 64'(wready_o[k]), 64'(0));
            check("rst_rvalid", 64'(rvalid_o[k]), 64'(0));
            check("rst_bvalid", 64'(bvalid_o[k]), 64'(0));
            check("rst_rdata", 64'(rdata_o[k]), 64'(0));
            check("rst_rresp", 64'(rresp_o[k]), 64'(0));
            check("rst_bresp", 64'(bresp_o[k]), 64'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("post_rst_arready", 64'(arready_o[k]), 64'(1));
            check("post_rst_awready", 64'(awready_o[k]), 64'(1));
            check("post_rst_wready", 64'(wready_o[k]), 64'(1));
        end

        // No-delay instance: write then read back, low address bits ignored
        do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read(0, 32'h8000_0010, 0, lat);
        do_read(0, 32'h8000_0013, 1, lat);

        // Fixed-delay instance: stall on R, partial strobes, AW/W ordering
        do_write(1, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, 0, 0);
        do_read(1, 32'h8000_0020, 5, lat);
        do_write(1, 32'h8000_0020, 32'h1122_3344, 4'b0101, 0, 0);
        do_read(1, 32'h8000_0020, 0, lat);
        check("partial_write", 64'(mem_m[1][8]), 64'(32'hAA22_CC44));
        do_write(1, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 1, 2);
        do_write(1, 32'h8000_0034, 32'h0BAD_C0DE, 4'hF, 2, 2);
        do_read(1, 32'h8000_0030, 0, lat);
        do_read(1, 32'h8000_0034, 0, lat);

        // Out-of-range accesses leave the edge words untouched
        do_write(0, BASE_A, 32'h0123_4567, 4'hF, 0, 0);
        do_write(0, 32'h8000_0FFC, 32'h89AB_CDEF, 4'hF, 0, 0);
        do_read(0, 32'h7FFF_FFFC, 0, lat);
        do_write(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2, 1);
        do_write(0, END_A, 32'hFFFF_FFFF, 4'hF, 1, 1);
        do_read(0, END_A, 0, lat);
        do_read(0, BASE_A, 0, lat);
        do_read(0, 32'h8000_0FFC, 0, lat);

        // Random-delay instance: fill a word pool, then random traffic
        for (int i = 0; i < 16; i++) begin
            do_write(2, BASE_A + 32'(pool[i] * 4), $urandom, 4'hF,
                     int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        end
        for (int it = 0; it < 200; it++) begin
            if (it % 10 == 5) begin
                do_write(2, BASE_A + 32'(pool[$urandom_range(0, 15)] * 4), $urandom,
                         4'($urandom_range(1, 15)), int'($urandom_range(0, 2)),
                         int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 15) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFF0 : END_A + 32'($urandom_range(0, 255));
            end else begin
                a = BASE_A + 32'(pool[$urandom_range(0, 15)] * 4) + 32'($urandom_range(0, 3));
            end
            do_read(2, a, int'($urandom_range(0, 2)), lat);
            check("rd_lat_in_mask", 64'(lat <= 15), 64'(1));
            if (lat >= 0 && lat < 16) seen[lat] = 1'b1;
        end
        distinct = 0;
        for (int i = 0; i < 16; i++) distinct += int'(seen[i]);
        check("distinct_latencies_ge8", 64'(distinct >= 8), 64'(1));

        // Reset while a read sits in R_WAIT and a write sits in W_WAIT
        guard = 0;
        while ((rd_lfsr_m[2] & 8'h0F) < 8'd2 && guard < 40) begin
            do_read(2, BASE_A, 0, lat);
            guard++;
        end
        araddr_i[2]  = BASE_A;
        arvalid_i[2] = 1'b1;
        awaddr_i[1]  = 32'h8000_0020;
        wdata_i[1]   = 32'h5555_5555;
        wstrb_i[1]   = 4'hF;
        awvalid_i[1] = 1'b1;
        wvalid_i[1]  = 1'b1;
        @(posedge clk); #1;
        arvalid_i[2] = 1'b0;
        awvalid_i[1] = 1'b0;
        wvalid_i[1]  = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_rvalid", 64'(rvalid_o[2]), 64'(0));
        check("pre_rst_bvalid", 64'(bvalid_o[1]), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_rvalid", 64'(rvalid_o[2]), 64'(0));
        check("mid_rst_arready", 64'(arready_o[2]), 64'(0));
        check("mid_rst_awready", 64'(awready_o[1]), 64'(0));
        check("mid_rst_wready", 64'(wready_o[1]), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_arready", 64'(arready_o[2]), 64'(1));
        check("rel_awready", 64'(awready_o[1]), 64'(1));
        reseed_models();
        do_read(1, 32'h8000_0020, 0, lat);
        do_read(2, BASE_A, 0, lat);
        do_write(2, BASE_A + 32'd8, 32'h7654_3210, 4'hF, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
